jtbubl_obj_lbuf: RTL and testbench

JTBUBL_OBJ_LBUF -- requirements
Module: jtbubl_obj_lbuf

---
 rtl/jtbubl_pkg.sv | 14 +
 rtl/jtbubl_lbuf_bank.sv | 39 +++
 rtl/jtbubl_obj_lbuf.sv | 141 ++++++++++++++
 tb/tb_jtbubl_obj_lbuf.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtbubl_pkg.sv
// Shared constants for the object line buffer: the transparent pen, the blank
// pixel value and the default line geometry.
package jtbubl_pkg;

    localparam int         LINE_AW = 8;
    localparam int         PXL_DW  = 8;
    localparam logic [3:0] TRANSP  = 4'hF;
    localparam logic [7:0] BLANK   = 8'hFF;

    function automatic logic is_transp(input logic [3:0] pen);
        return pen == TRANSP;
    endfunction

endpackage

// File: rtl/jtbubl_lbuf_bank.sv
// One line bank: write port A for the renderer, read port B for scan-out and a
// port B write that blanks whatever port B read last.
module jtbubl_lbuf_bank #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          i_we_a,
    input  logic [AW-1:0] i_addr_a,
    input  logic [DW-1:0] i_din_a,
    input  logic          i_re_b,
    input  logic [AW-1:0] i_addr_b,
    input  logic          i_clr_b,
    input  logic [DW-1:0] i_clr_data,
    output logic [DW-1:0] o_dout_b
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [AW-1:0] r_addr_b;
    logic [DW-1:0] r_dout_b;

    // The clear reuses the latched read address, so a read and the clear of
    // the previous location may share a clk.
    always_ff @(posedge clk) begin
        if (i_we_a) begin
            r_mem[i_addr_a] <= i_din_a;
        end
        if (i_clr_b) begin
            r_mem[r_addr_b] <= i_clr_data;
        end
        if (i_re_b) begin
            r_dout_b <= r_mem[i_addr_b];
            r_addr_b <= i_addr_b;
        end
    end

    assign o_dout_b = r_dout_b;

endmodule

// File: rtl/jtbubl_obj_lbuf.sv
// Double-buffered object line buffer with scan-and-clear. Define
// JTBUBL_LBUF_PRIO_EN for first-wins writes (2-clk read-before-write pipeline).
module jtbubl_obj_lbuf
    import jtbubl_pkg::*;
#(
    parameter int AW = LINE_AW,
    parameter int DW = PXL_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic [8:0]    hdump,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] col_addr,
    output logic          line_sel
);

    localparam logic [DW-1:0] BLANK_DW = DW'(BLANK);

    logic          r_lhbl_l, r_line_sel, r_rd_pend, r_clr_en, r_clr_bank;
    logic [1:0]    r_line_cnt;
    logic [DW-1:0] r_col_addr;

    logic          w_lhbl_fall, w_scan_rd, w_scan_bank, w_wr_bank, w_wr_opaque, w_warm;
    logic [AW-1:0] w_scan_addr;
    logic [DW-1:0] w_scan_dout;
    logic [DW-1:0] w_dout [2];
    logic [1:0]    w_b_scan, w_p_rd, w_b_re;
    logic          w_a_we, w_a_bank;
    logic [AW-1:0] w_a_addr;
    logic [DW-1:0] w_a_data;
    logic          w_unused;

    assign w_lhbl_fall = pxl_cen && r_lhbl_l && !LHBL;
    assign w_scan_rd   = pxl_cen && LHBL;
    assign w_scan_bank = !r_line_sel;
    // A write landing on the swap edge already belongs to the new line.
    assign w_wr_bank   = w_lhbl_fall ? !r_line_sel : r_line_sel;
    assign w_wr_opaque = !is_transp(wr_data[3:0]);
    assign w_scan_addr = hdump[AW-1:0];
    assign w_scan_dout = r_line_sel ? w_dout[0] : w_dout[1];
    assign w_warm      = (r_line_cnt == 2'd3);
    assign w_unused    = ^hdump[8:AW];

    // The counter saturates after the partial line in progress at reset
    // release plus two complete lines; output is blank until then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lhbl_l   <= 1'b0;
            r_line_sel <= 1'b0;
            r_line_cnt <= 2'd0;
            r_rd_pend  <= 1'b0;
            r_clr_en   <= 1'b0;
            r_clr_bank <= 1'b0;
            r_col_addr <= BLANK_DW;
        end else begin
            r_clr_en   <= w_scan_rd;
            r_clr_bank <= w_scan_bank;
            if (pxl_cen) begin
                r_lhbl_l   <= LHBL;
                r_rd_pend  <= LHBL;
                r_col_addr <= (r_rd_pend && w_warm) ? w_scan_dout : BLANK_DW;
                if (w_lhbl_fall) begin
                    r_line_sel <= !r_line_sel;
                    if (!w_warm) begin
                        r_line_cnt <= r_line_cnt + 2'd1;
                    end
                end
            end
        end
    end

    assign col_addr = r_col_addr;
    assign line_sel = r_line_sel;

`ifdef JTBUBL_LBUF_PRIO_EN
    logic          r_p_vld, r_p_bank;
    logic [AW-1:0] r_p_addr;
    logic [DW-1:0] r_p_data;
    logic [3:0]    w_p_pen;

    // Stage 1 reads the destination through the idle port B of the write bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_vld  <= 1'b0;
            r_p_bank <= 1'b0;
            r_p_addr <= '0;
            r_p_data <= '0;
        end else begin
            r_p_vld <= wr_en && w_wr_opaque;
            if (wr_en) begin
                r_p_bank <= w_wr_bank;
                r_p_addr <= wr_addr;
                r_p_data <= wr_data;
            end
        end
    end

    assign w_p_pen  = r_p_bank ? w_dout[1][3:0] : w_dout[0][3:0];
    assign w_a_we   = r_p_vld && is_transp(w_p_pen);
    assign w_a_bank = r_p_bank;
    assign w_a_addr = r_p_addr;
    assign w_a_data = r_p_data;
`else
    assign w_a_we   = wr_en && w_wr_opaque;
    assign w_a_bank = w_wr_bank;
    assign w_a_addr = wr_addr;
    assign w_a_data = wr_data;
`endif

    always_comb begin
        w_b_scan = '0;
        w_p_rd   = '0;
        w_b_scan[w_scan_bank] = w_scan_rd;
`ifdef JTBUBL_LBUF_PRIO_EN
        w_p_rd[w_wr_bank] = wr_en && w_wr_opaque;
`endif
        w_b_re = w_b_scan | w_p_rd;
    end

    for (genvar k = 0; k < 2; k++) begin : g_bank
        jtbubl_lbuf_bank #(
            .AW (AW),
            .DW (DW)
        ) u_bank (
            .clk        (clk),
            .i_we_a     (w_a_we && (w_a_bank == 1'(k))),
            .i_addr_a   (w_a_addr),
            .i_din_a    (w_a_data),
            .i_re_b     (w_b_re[k]),
            .i_addr_b   (w_b_scan[k] ? w_scan_addr : wr_addr),
            .i_clr_b    (r_clr_en && (r_clr_bank == 1'(k))),
            .i_clr_data (BLANK_DW),
            .o_dout_b   (w_dout[k])
        );
    end

endmodule

// File: tb/tb_jtbubl_obj_lbuf.sv
// Scoreboard bench for jtbubl_obj_lbuf: directed lines with hand-computed
// pixels, checked by a monitor on every pixel-enable output update.
module tb_jtbubl_obj_lbuf;

  localparam logic [8:0] HD_START  = 9'h0F8;
  localparam logic [8:0] BLK_START = 9'h110;
  localparam int         ACT_PX    = 24;
  localparam int         LINE_PX   = 28;
`ifdef JTBUBL_LBUF_PRIO_EN
  localparam logic [7:0] EXP_DUP = 8'h12;
`else
  localparam logic [7:0] EXP_DUP = 8'h34;
`endif

  logic       clk, rst_n, pxl_cen, LHBL, wr_en, line_sel;
  logic [8:0] hdump;
  logic [7:0] wr_addr, wr_data, col_addr;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard entry: {line[7:0], hdump[8:0], expected col_addr[7:0]}
  logic [24:0] exp_q[$];
  logic [7:0]  wq_addr[$];
  logic [7:0]  wq_data[$];

  logic [7:0] cur_line = 8'd0;
  logic       cen_wr_v = 1'b0;
  logic [7:0] cen_wr_addr = 8'd0;
  logic [7:0] cen_wr_data = 8'd0;

  jtbubl_obj_lbuf #(.AW(8), .DW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .hdump    (hdump),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .col_addr (col_addr),
    .line_sel (line_sel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: simulation still running, required to finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h required %02h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wq_addr.push_back(a);
    wq_data.push_back(d);
  endtask

  task automatic expect_px(input logic [7:0] line, input logic [8:0] hd, input logic [7:0] val);
    exp_q.push_back({line, hd, val});
  endtask

  task automatic tick(input logic [8:0] hd, input logic lh);
    hdump = hd;
    LHBL  = lh;
    @(negedge clk);
    pxl_cen = 1'b1;
    if (cen_wr_v) begin
      wr_en    = 1'b1;
      wr_addr  = cen_wr_addr;
      wr_data  = cen_wr_data;
      cen_wr_v = 1'b0;
    end
    @(negedge clk);
    pxl_cen = 1'b0;
    wr_en   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if ((i % 2 == 0) && (wq_addr.size() > 0)) begin
        wr_en   = 1'b1;
        wr_addr = wq_addr.pop_front();
        wr_data = wq_data.pop_front();
      end
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  task automatic run_line(input int first_p, input int last_p, input bit fall_wr);
    if (first_p == 0) cur_line = cur_line + 8'd1;
    for (int p = first_p; p <= last_p; p++) begin
      if (p == ACT_PX && fall_wr) cen_wr_v = 1'b1;
      if (p < ACT_PX) tick(9'(HD_START + 9'(p)), 1'b1);
      else            tick(9'(BLK_START + 9'(p - ACT_PX)), 1'b0);
    end
  endtask

  // monitor: each pixel enable presents the pixel requested on the previous one
  logic [7:0]  pv_line = 8'd0, sh_line;
  logic [8:0]  pv_hd = 9'd0, sh_hd;
  logic [24:0] mon_e;

  initial begin
    forever begin
      @(posedge clk);
      if (pxl_cen === 1'b1) begin
        sh_line = pv_line;
        sh_hd   = pv_hd;
        pv_line = cur_line;
        pv_hd   = hdump;
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0][24:17] == sh_line && exp_q[0][16:8] == sh_hd) begin
          mon_e = exp_q.pop_front();
          check($sformatf("pix_line%0d_hd%03h", sh_line, sh_hd), col_addr, mon_e[7:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b0; hdump = 9'd0;
    wr_en = 1'b0; wr_addr = 8'd0; wr_data = 8'd0;
    repeat (4) @(negedge clk);
    check("reset_col_addr", col_addr, 8'hFF);
    check("reset_line_sel", {7'd0, line_sel}, 8'h00);
    rst_n = 1'b1;

    // startup lines are forced blank even with data written
    push_wr(8'd10, 8'h23);
    expect_px(8'd2, 9'h10A, 8'hFF);
    expect_px(8'd3, 9'h103, 8'hFF);
    expect_px(8'd3, 9'h10A, 8'hFF);
    run_line(0, LINE_PX - 1, 1'b0);
    check("line_sel_after_l1", {7'd0, line_sel}, 8'h01);
    push_wr(8'd3, 8'h56);
    run_line(0, LINE_PX - 1, 1'b0);
    check("line_sel_after_l2", {7'd0, line_sel}, 8'h00);
    run_line(0, LINE_PX - 1, 1'b0);

    // line 4 renders, line 5 shows it
    push_wr(8'd10,  8'h23);
    push_wr(8'd5,   8'h4F);
    push_wr(8'd7,   8'h12);
    push_wr(8'd7,   8'h34);
    push_wr(8'd250, 8'h61);
    push_wr(8'd0,   8'h70);
    push_wr(8'd15,  8'h2E);
    expect_px(8'd5, 9'h0FA, 8'h61);
    expect_px(8'd5, 9'h100, 8'h70);
    expect_px(8'd5, 9'h105, 8'hFF);
    expect_px(8'd5, 9'h107, EXP_DUP);
    expect_px(8'd5, 9'h10A, 8'h23);
    expect_px(8'd5, 9'h10B, 8'hFF);
    expect_px(8'd5, 9'h10F, 8'h2E);
    expect_px(8'd5, 9'h111, 8'hFF);
    run_line(0, LINE_PX - 1, 1'b0);
    run_line(0, LINE_PX - 1, 1'b0);

    // two swaps without writes: scanned data must be gone
    expect_px(8'd6, 9'h10A, 8'hFF);
    expect_px(8'd7, 9'h0FA, 8'hFF);
    expect_px(8'd7, 9'h10A, 8'hFF);
    run_line(0, LINE_PX - 1, 1'b0);

    // write on the swap edge goes to the new write bank
    cen_wr_addr = 8'd12;
    cen_wr_data = 8'h5A;
    expect_px(8'd8, 9'h10C, 8'hFF);
    expect_px(8'd9, 9'h10C, 8'h5A);
    run_line(0, LINE_PX - 1, 1'b1);
    run_line(0, LINE_PX - 1, 1'b0);

    // preload bank 0 during line 9, then reset mid line 10
    push_wr(8'd10, 8'h23);
    push_wr(8'd14, 8'h66);
    run_line(0, LINE_PX - 1, 1'b0);
    run_line(0, 11, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_col_addr", col_addr, 8'hFF);
    check("rst_mid_line_sel", {7'd0, line_sel}, 8'h00);
    for (int l = 11; l <= 12; l++) begin
      for (int p = 0; p < ACT_PX; p++) begin
        expect_px(8'(l), 9'(HD_START + 9'(p)), 8'hFF);
      end
    end
    run_line(12, 13, 1'b0);
    rst_n = 1'b1;
    run_line(14, LINE_PX - 1, 1'b0);
    check("line_sel_after_rst_line", {7'd0, line_sel}, 8'h01);
    run_line(0, LINE_PX - 1, 1'b0);
    run_line(0, LINE_PX - 1, 1'b0);

    // normal output resumes
    push_wr(8'd9, 8'h3C);
    expect_px(8'd14, 9'h109, 8'h3C);
    expect_px(8'd14, 9'h10A, 8'hFF);
    run_line(0, LINE_PX - 1, 1'b0);
    run_line(0, LINE_PX - 1, 1'b0);

    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL unobserved_line%0d_hd%03h: got no output, required %02h",
               mon_e[24:17], mon_e[16:8], mon_e[7:0]);
    end

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
